// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 timing generator: pixel-rate enable, sync-origin counters,
// registered sync/bright decode, frame strobe and frame counter.
module vga_sync_gen #(
    parameter int PIX_DIV = 4,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_VIS + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_VIS + V_FP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_sync_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end
    if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_div
        $error("vga_sync_gen: PIX_DIV must be in 1..16");
    end

    localparam logic [3:0] DIV_LAST = 4'(PIX_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SW     = 10'(H_SYNC);
    localparam logic [9:0] V_SW     = 10'(V_SYNC);
    localparam logic [9:0] H_VIS0   = 10'(H_SYNC + H_BP);
    localparam logic [9:0] V_VIS0   = 10'(V_SYNC + V_BP);
    // End bounds are exclusive and may equal 1024, so compare in 11 bits.
    localparam logic [10:0] H_VIS1  = 11'(H_SYNC + H_BP + H_VIS);
    localparam logic [10:0] V_VIS1  = 11'(V_SYNC + V_BP + V_VIS);

    logic [3:0] div;
    logic       h_last;
    logic       v_last;
    logic       wrap;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       h_vis;
    logic       v_vis;

    assign h_last = (hCount == H_LAST);
    assign v_last = (vCount == V_LAST);
    assign wrap   = pix_en && h_last && v_last;

    always_comb begin
        h_nxt = hCount;
        v_nxt = vCount;
        if (pix_en) begin
            h_nxt = h_last ? 10'd0 : hCount + 10'd1;
            if (h_last) begin
                v_nxt = v_last ? 10'd0 : vCount + 10'd1;
            end
        end
    end

    assign h_vis = (h_nxt >= H_VIS0) && ({1'b0, h_nxt} < H_VIS1);
    assign v_vis = (v_nxt >= V_VIS0) && ({1'b0, v_nxt} < V_VIS1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div         <= 4'd0;
            pix_en      <= 1'b0;
            hCount      <= 10'd0;
            vCount      <= 10'd0;
            hSync       <= 1'b0;
            vSync       <= 1'b0;
            bright      <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            div         <= (div == DIV_LAST) ? 4'd0 : div + 4'd1;
            pix_en      <= (div == DIV_LAST);
            hCount      <= h_nxt;
            vCount      <= v_nxt;
            // Decoded from next-state counts so they line up with hCount/vCount.
            hSync       <= !(h_nxt < H_SW);
            vSync       <= !(v_nxt < V_SW);
            bright      <= h_vis && v_vis;
            frame_start <= wrap;
            if (wrap) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: three builds (default timing, small
// timing at PIX_DIV=1 and PIX_DIV=3) checked every clk against a cycle-count model.
module tb_vga_sync_gen;

    typedef struct packed {
        logic       pe;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       br;
        logic       fs;
        logic [7:0] fc;
    } exp_t;

    typedef struct packed {
        int p;
        int hs; int hbp; int hvis; int hfp;
        int vs; int vbp; int vvis; int vfp;
    } cfg_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       pe_a, hs_a, vs_a, br_a, fs_a;
    logic [9:0] h_a, v_a;
    logic [7:0] fc_a;
    logic       pe_b, hs_b, vs_b, br_b, fs_b;
    logic [9:0] h_b, v_b;
    logic [7:0] fc_b;
    logic       pe_c, hs_c, vs_c, br_c, fs_c;
    logic [9:0] h_c, v_c;
    logic [7:0] fc_c;

    vga_sync_gen u_a (
        .clk(clk), .rst(rst), .pix_en(pe_a), .hCount(h_a), .vCount(v_a),
        .hSync(hs_a), .vSync(vs_a), .bright(br_a),
        .frame_start(fs_a), .frame_cnt(fc_a)
    );

    vga_sync_gen #(
        .PIX_DIV(1), .H_SYNC(3), .H_BP(2), .H_VIS(8), .H_FP(2),
        .V_SYNC(2), .V_BP(2), .V_VIS(5), .V_FP(1)
    ) u_b (
        .clk(clk), .rst(rst), .pix_en(pe_b), .hCount(h_b), .vCount(v_b),
        .hSync(hs_b), .vSync(vs_b), .bright(br_b),
        .frame_start(fs_b), .frame_cnt(fc_b)
    );

    vga_sync_gen #(
        .PIX_DIV(3), .H_SYNC(3), .H_BP(2), .H_VIS(8), .H_FP(2),
        .V_SYNC(2), .V_BP(2), .V_VIS(5), .V_FP(1)
    ) u_c (
        .clk(clk), .rst(rst), .pix_en(pe_c), .hCount(h_c), .vCount(v_c),
        .hSync(hs_c), .vSync(vs_c), .bright(br_c),
        .frame_start(fs_c), .frame_cnt(fc_c)
    );

    exp_t act [3];
    assign act[0] = {pe_a, h_a, v_a, hs_a, vs_a, br_a, fs_a, fc_a};
    assign act[1] = {pe_b, h_b, v_b, hs_b, vs_b, br_b, fs_b, fc_b};
    assign act[2] = {pe_c, h_c, v_c, hs_c, vs_c, br_c, fs_c, fc_c};

    exp_t q [3][$];
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;
    int   b_fs_seen = 0;
    int   b_wraps   = 0;

    function automatic cfg_t cfg(input int i);
        cfg_t c;
        case (i)
            0:       c = '{p:4, hs:96, hbp:48, hvis:640, hfp:16,
                           vs:2, vbp:33, vvis:480, vfp:10};
            1:       c = '{p:1, hs:3, hbp:2, hvis:8, hfp:2,
                           vs:2, vbp:2, vvis:5, vfp:1};
            default: c = '{p:3, hs:3, hbp:2, hvis:8, hfp:2,
                           vs:2, vbp:2, vvis:5, vfp:1};
        endcase
        return c;
    endfunction

    // n = clk edges since reset release (first edge is 0).
    function automatic exp_t model(input int n, input cfg_t c);
        exp_t e;
        int ht, vt, k, p, h, v, x0, y0;
        ht = c.hs + c.hbp + c.hvis + c.hfp;
        vt = c.vs + c.vbp + c.vvis + c.vfp;
        k  = n / c.p;
        p  = k % (ht * vt);
        h  = p % ht;
        v  = p / ht;
        x0 = c.hs + c.hbp;
        y0 = c.vs + c.vbp;
        e.pe = ((n % c.p) == c.p - 1);
        e.h  = 10'(h);
        e.v  = 10'(v);
        e.hs = (h >= c.hs);
        e.vs = (v >= c.vs);
        e.br = (h >= x0) && (h < x0 + c.hvis) && (v >= y0) && (v < y0 + c.vvis);
        e.fs = (k > 0) && (p == 0) && ((n % c.p) == 0);
        e.fc = 8'((k / (ht * vt)) % 256);
        return e;
    endfunction

    task automatic check(input string nm, input exp_t a, input exp_t e);
        checks++;
        if (a === e) begin
            passes++;
        end else begin
            fails++;
            if (fails <= 20)
                $display("FAIL %s: got pe=%0b h=%0d v=%0d hs=%0b vs=%0b br=%0b fs=%0b fc=%0d, expected pe=%0b h=%0d v=%0d hs=%0b vs=%0b br=%0b fs=%0b fc=%0d",
                         nm, a.pe, a.h, a.v, a.hs, a.vs, a.br, a.fs, a.fc,
                         e.pe, e.h, e.v, e.hs, e.vs, e.br, e.fs, e.fc);
        end
    endtask

    task automatic check_int(input string nm, input int a, input int e);
        checks++;
        if (a == e) begin
            passes++;
        end else begin
            fails++;
            if (fails <= 20)
                $display("FAIL %s: got %0d, expected %0d", nm, a, e);
        end
    endtask

    // Reference side: one expected entry per instance per clk edge.
    initial begin
        int n [3];
        for (int i = 0; i < 3; i++) n[i] = 0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rst) begin
                    n[i] = 0;
                    q[i].push_back('0);
                end else begin
                    q[i].push_back(model(n[i], cfg(i)));
                    n[i]++;
                end
            end
        end
    end

    // Monitor side: pops and compares away from the active edge.
    initial begin
        int cyc;
        int last_fs;
        exp_t e;
        cyc = 0;
        last_fs = -1;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (q[i].size() > 0) begin
                    e = q[i].pop_front();
                    check($sformatf("dut%0d_cyc%0d", i, cyc), act[i], e);
                end
            end
            if (rst) begin
                last_fs = -1;
            end else begin
                if (fs_b) begin
                    if (last_fs >= 0)
                        check_int("b_frame_period", cyc - last_fs, 150);
                    last_fs = cyc;
                    b_fs_seen++;
                end
                if (fs_b && fc_b == 8'd0) b_wraps++;
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat ($urandom_range(1500, 400)) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("async_rst_dut%0d", i), act[i], '0);
        repeat ($urandom_range(3, 1)) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (60000) @(posedge clk);
        @(negedge clk);
        #1;
        check_int("b_frames_seen_min", (b_fs_seen >= 300) ? 1 : 0, 1);
        check_int("b_cnt_wrapped", (b_wraps >= 1) ? 1 : 0, 1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
